switch_debouncer: RTL and testbench

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

---
 rtl/debounce_pkg.sv | 12 +
 rtl/debounce_bit.sv | 59 +++++
 rtl/switch_debouncer.sv | 66 ++++++
 tb/tb_switch_debouncer.sv | 116 +++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared defaults and per-bit FSM state encoding for the switch debouncer.
package debounce_pkg;

  localparam int DEFAULT_WIDTH         = 10;
  localparam int DEFAULT_STABLE_CYCLES = 100000;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } db_state_e;

endpackage

// File: rtl/debounce_bit.sv
// One debounced switch bit: accepts a new level only after STABLE_CYCLES
// consecutive differing samples; any matching sample discards the count.
module debounce_bit
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic s_i,
  output logic o_o,
  output logic upd_o
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  db_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic          o_q;

  // High exactly on the edge where o_q takes the new level.
  assign upd_o = (state_q == COUNTING) && (s_i != o_q) && (cnt_q == CNT_MAX);
  assign o_o   = o_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      o_q     <= 1'b0;
    end else begin
      case (state_q)
        STABLE: begin
          if (s_i != o_q) begin
            cnt_q   <= CW'(1);
            state_q <= COUNTING;
          end
        end
        COUNTING: begin
          if (s_i == o_q) begin
            cnt_q   <= '0;
            state_q <= STABLE;
          end else if (cnt_q == CNT_MAX) begin
            o_q     <= s_i;
            cnt_q   <= '0;
            state_q <= STABLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= STABLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// WIDTH-bit switch debouncer with a single change pulse.
// Define SWITCH_DEBOUNCER_SYNC_EN to insert a two-flop input synchronizer.
module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] o,
  output logic             chg
);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] upd;
  logic             chg_q;
  logic             chg_d;

`ifdef SWITCH_DEBOUNCER_SYNC_EN
  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= sw_in;
      sync_q <= meta_q;
    end
  end

  assign s = sync_q;
`else
  assign s = sw_in;
`endif

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      debounce_bit #(
        .STABLE_CYCLES(STABLE_CYCLES)
      ) u_bit (
        .clk  (clk),
        .rst  (rst),
        .s_i  (s[gi]),
        .o_o  (o[gi]),
        .upd_o(upd[gi])
      );
    end
  endgenerate

  // Any number of simultaneous bit updates folds into one pulse.
  always_comb begin
    chg_d = |upd;
  end

  always_ff @(posedge clk) begin
    if (rst) chg_q <= 1'b0;
    else     chg_q <= chg_d;
  end

  assign chg = chg_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer (STABLE_CYCLES=4, no synchronizer).
module tb_switch_debouncer;

  localparam int W = 10;

  typedef struct packed {
    logic [W-1:0] o;
    logic         chg;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw_in = '0;
  logic [W-1:0] o;
  logic         chg;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  switch_debouncer #(
    .WIDTH(W),
    .STABLE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .sw_in(sw_in),
    .o    (o),
    .chg  (chg)
  );

  // Drive one cycle of stimulus, queue what the outputs must be after the
  // next rising edge, then pop and compare on the falling edge.
  task automatic cycle(input string tag, input logic r, input logic [W-1:0] sw,
                       input logic [W-1:0] eo, input logic ec);
    exp_t e;
    rst   = r;
    sw_in = sw;
    sb_q.push_back('{o: eo, chg: ec});
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    checks++;
    assert (o === e.o) else begin
      errors++;
      $error("FAIL %s o=%h expected %h", tag, o, e.o);
    end
    checks++;
    assert (chg === e.chg) else begin
      errors++;
      $error("FAIL %s chg=%b expected %b", tag, chg, e.chg);
    end
  endtask

  initial begin
    @(negedge clk);
    // Reset state
    cycle("reset0", 1'b1, 10'h000, 10'h000, 1'b0);
    cycle("reset1", 1'b1, 10'h3FF, 10'h000, 1'b0);

    // Single bit rises: update at the 4th edge, one-cycle chg after it
    for (int i = 0; i < 3; i++) cycle("b0_rise_wait", 1'b0, 10'h001, 10'h000, 1'b0);
    cycle("b0_rise_upd", 1'b0, 10'h001, 10'h001, 1'b1);
    cycle("b0_rise_hold", 1'b0, 10'h001, 10'h001, 1'b0);
    cycle("b0_rise_hold2", 1'b0, 10'h001, 10'h001, 1'b0);

    // Same bit falls back
    for (int i = 0; i < 3; i++) cycle("b0_fall_wait", 1'b0, 10'h000, 10'h001, 1'b0);
    cycle("b0_fall_upd", 1'b0, 10'h000, 10'h000, 1'b1);
    cycle("b0_fall_hold", 1'b0, 10'h000, 10'h000, 1'b0);

    // Bit 3 glitch of 3 edges is rejected, then a 4-edge hold is accepted
    for (int i = 0; i < 3; i++) cycle("b3_glitch", 1'b0, 10'h008, 10'h000, 1'b0);
    for (int i = 0; i < 2; i++) cycle("b3_glitch_end", 1'b0, 10'h000, 10'h000, 1'b0);
    for (int i = 0; i < 3; i++) cycle("b3_hold_wait", 1'b0, 10'h008, 10'h000, 1'b0);
    cycle("b3_hold_upd", 1'b0, 10'h008, 10'h008, 1'b1);
    cycle("b3_hold_after", 1'b0, 10'h008, 10'h008, 1'b0);

    // Bit 0 rises while bit 5 chatters: bits stay independent
    cycle("indep_1", 1'b0, 10'h029, 10'h008, 1'b0);
    cycle("indep_2", 1'b0, 10'h009, 10'h008, 1'b0);
    cycle("indep_3", 1'b0, 10'h029, 10'h008, 1'b0);
    cycle("indep_4", 1'b0, 10'h009, 10'h009, 1'b1);
    cycle("indep_5", 1'b0, 10'h009, 10'h009, 1'b0);

    // All bits step together: one shared update edge and one pulse
    for (int i = 0; i < 3; i++) cycle("all_wait", 1'b0, 10'h3FF, 10'h009, 1'b0);
    cycle("all_upd", 1'b0, 10'h3FF, 10'h3FF, 1'b1);
    cycle("all_hold", 1'b0, 10'h3FF, 10'h3FF, 1'b0);

    // Reset from all-ones, then reset mid-count on bit 4 discards the count
    cycle("rst_from_ones", 1'b1, 10'h010, 10'h000, 1'b0);
    for (int i = 0; i < 2; i++) cycle("b4_count", 1'b0, 10'h010, 10'h000, 1'b0);
    cycle("b4_midrst", 1'b1, 10'h010, 10'h000, 1'b0);
    for (int i = 0; i < 3; i++) cycle("b4_restart", 1'b0, 10'h010, 10'h000, 1'b0);
    cycle("b4_upd", 1'b0, 10'h010, 10'h010, 1'b1);
    cycle("b4_hold", 1'b0, 10'h010, 10'h010, 1'b0);

    // Long hold at a new level: counter must not wrap into a second update
    for (int i = 0; i < 3; i++) cycle("long_wait", 1'b0, 10'h000, 10'h010, 1'b0);
    cycle("long_upd", 1'b0, 10'h000, 10'h000, 1'b1);
    for (int i = 0; i < 8; i++) cycle("long_hold", 1'b0, 10'h000, 10'h000, 1'b0);

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain size=%0d expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
